floor_issue_arbiter: RTL

Round-robin issue controller that shares one floor pipeline (2-cycle latency, no stall input) among `NUM_REQ` requesters. It accepts one operand per cycle over valid/ready and drives the pipeline input. It tracks each in-flight operation's requester id and tag, and captures pipeline results in an in-order response FIFO. A credit counter guarantees no result is lost when the response consumer back-pressures. The block sits between the FPU dispatch ports and the floor datapath.

---
 rtl/floor_issue_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/floor_issue_arbiter.sv
// Round-robin issue of NUM_REQ operand streams into a fixed-latency floor pipeline.
// Results are captured into an in-order response FIFO; a credit count keeps issue from overrunning it.
module floor_issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int PIPE_LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_data,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [31:0]                pipe_a,
    input  logic [31:0]                pipe_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CR_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic             vld;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } trk_t;

    typedef struct packed {
        logic [31:0]      dat;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_id, cand;
    logic             grant_vld, issue_ok, hs, push, pop;
    logic [TAG_W-1:0] grant_tag;
    logic [CR_W-1:0]  credits_q, credits_d;
    logic [AW:0]      wr_q, rd_q;
    trk_t             trk_q [PIPE_LAT];
    trk_t             trk_d;
    rsp_t             mem_q [FIFO_DEPTH];
    rsp_t             head;

    // A pop in this cycle deliberately does not count toward freeing a credit.
    always_comb begin
        issue_ok  = !rst && (credits_q < CR_W'(FIFO_DEPTH));
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
        hs        = issue_ok && grant_vld;
        req_ready = '0;
        pipe_a    = '0;
        grant_tag = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (hs && grant_id == ID_W'(k)) begin
                req_ready[k] = 1'b1;
                pipe_a       = req_data[k*32 +: 32];
                grant_tag    = req_tag[k*TAG_W +: TAG_W];
            end
        end
        trk_d = {hs, grant_id, grant_tag};
        ptr_d = hs ? ID_W'((int'(grant_id) + 1) % NUM_REQ) : ptr_q;
    end

    always_comb begin
        push      = trk_q[PIPE_LAT-1].vld;
        rsp_valid = (wr_q != rd_q);
        pop       = rsp_valid && rsp_ready;
        head      = mem_q[rd_q[AW-1:0]];
        rsp_data  = rsp_valid ? head.dat : '0;
        rsp_id    = rsp_valid ? head.id  : '0;
        rsp_tag   = rsp_valid ? head.tag : '0;
        busy      = (credits_q != '0);
        case ({hs, pop})
            2'b10:   credits_d = credits_q + CR_W'(1);
            2'b01:   credits_d = credits_q - CR_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            credits_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            for (int s = 0; s < PIPE_LAT; s++) trk_q[s] <= '0;
        end else begin
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            trk_q[0]  <= trk_d;
            for (int s = 1; s < PIPE_LAT; s++) trk_q[s] <= trk_q[s-1];
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {pipe_result, trk_q[PIPE_LAT-1].id, trk_q[PIPE_LAT-1].tag};
    end

endmodule
